// File: rtl/u_fetch.sv
// u_fetch: MIPS instruction-fetch stage.
// Owns the PC, instruction memory and the IF/ID latch.
//
// Ports:
//   i_clock, i_reset      clock, sync active-high reset
//   i_enable, i_step      run enable / step pulse
//                         (i_step only with FETCH_STEP_EN)
//   i_stall               hold PC and IF/ID
//   i_jump, i_pcjump      ID-stage redirect
//   i_branch, i_pcbranch  EX-stage redirect
//   i_load_*              program-load write port
//   o_pc                  current fetch PC
//   o_currentpc,
//   o_instruccion,
//   o_valid               IF/ID latch
//   o_halted              fetch sits in HALT
//
// Macro FETCH_STEP_EN adds single-step gating.
module u_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
`ifdef FETCH_STEP_EN
  input  logic                  i_step,
`endif
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_branch,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic                  o_valid,
  output logic                  o_halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  is_halt;
  logic                  active;
  logic                  run;
  logic                  moving;
  logic                  do_branch;
  logic                  do_jump;
  logic                  do_adv;
  logic                  do_bubble;
  state_t                state;
  state_t                state_nx;

`ifdef FETCH_STEP_EN
  assign active = i_enable & i_step;
`else
  assign active = i_enable;
`endif

  // Async read; a same-edge write lands after the
  // fetch, so the old word is what gets latched.
  assign fetch_word = mem[o_pc[ADDR_WIDTH-1:0]];
  assign is_halt =
    fetch_word[DATA_WIDTH-1 -: 6] == HALT_OPCODE;

  assign run    = (state == RUN);
  // Branch outranks stall; everything else needs
  // both branch and stall low.
  assign do_branch = active & i_branch;
  assign moving    = active & ~i_branch & ~i_stall;
  assign do_jump   = moving & run & i_jump;
  assign do_adv    = moving & run & ~i_jump;
  assign do_bubble = moving & ~run;

  always_ff @(posedge i_clock) begin
    if (i_load_we)
      mem[i_load_addr] <= i_load_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)
      state <= RUN;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      do_branch: state_nx = RUN;
      do_adv:    if (is_halt) state_nx = HALT;
      default:   state_nx = state;
    endcase
  end

  always_comb begin
    o_halted = (state == HALT);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_pc          <= '0;
      o_currentpc   <= '0;
      o_instruccion <= '0;
      o_valid       <= 1'b0;
    end else begin
      unique case (1'b1)
        do_branch: begin
          o_pc          <= i_pcbranch;
          o_currentpc   <= '0;
          o_instruccion <= '0;
          o_valid       <= 1'b0;
        end
        do_jump: begin
          o_pc          <= i_pcjump;
          o_currentpc   <= '0;
          o_instruccion <= '0;
          o_valid       <= 1'b0;
        end
        do_bubble: begin
          o_currentpc   <= '0;
          o_instruccion <= '0;
          o_valid       <= 1'b0;
        end
        do_adv: begin
          o_currentpc   <= o_pc;
          o_instruccion <= fetch_word;
          o_valid       <= 1'b1;
          // PC parks on the HALT word.
          if (!is_halt)
            o_pc <= o_pc + DATA_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_u_fetch.sv
// tb_u_fetch: randomized + directed bench for u_fetch
// against a behavioural model of the fetch rules.
module tb_u_fetch;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b0;
`ifdef FETCH_STEP_EN
  logic        i_step = 1'b0;
`endif
  logic        i_stall = 1'b0;
  logic        i_jump = 1'b0;
  logic [31:0] i_pcjump = '0;
  logic        i_branch = 1'b0;
  logic [31:0] i_pcbranch = '0;
  logic        i_load_we = 1'b0;
  logic [7:0]  i_load_addr = '0;
  logic [31:0] i_load_data = '0;
  logic [31:0] o_pc;
  logic [31:0] o_currentpc;
  logic [31:0] o_instruccion;
  logic        o_valid;
  logic        o_halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_pc = '0;
  logic [31:0] m_cur = '0;
  logic [31:0] m_ins = '0;
  logic        m_v = 1'b0;
  logic        m_h = 1'b0;

  logic [97:0] act_v;
  logic [97:0] exp_v;

  // PC of a bubble is don't-care: masked by model valid.
  assign act_v = {o_pc, m_v ? o_currentpc : 32'h0,
                  o_instruccion, o_valid, o_halted};
  assign exp_v = {m_pc, m_v ? m_cur : 32'h0,
                  m_ins, m_v, m_h};

  u_fetch dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
`ifdef FETCH_STEP_EN
    .i_step       (i_step),
`endif
    .i_stall      (i_stall),
    .i_jump       (i_jump),
    .i_pcjump     (i_pcjump),
    .i_branch     (i_branch),
    .i_pcbranch   (i_pcbranch),
    .i_load_we    (i_load_we),
    .i_load_addr  (i_load_addr),
    .i_load_data  (i_load_data),
    .o_pc         (o_pc),
    .o_currentpc  (o_currentpc),
    .o_instruccion(o_instruccion),
    .o_valid      (o_valid),
    .o_halted     (o_halted)
  );

  always #5 i_clock = ~i_clock;

  task automatic model_step();
    logic act;
    logic [31:0] w;
    act = i_enable;
`ifdef FETCH_STEP_EN
    act = act & i_step;
`endif
    w = m_mem[m_pc[7:0]];
    if (i_reset) begin
      m_pc = 0; m_cur = 0; m_ins = 0;
      m_v = 0; m_h = 0;
    end else if (act) begin
      if (i_branch) begin
        m_pc = i_pcbranch; m_cur = 0;
        m_ins = 0; m_v = 0; m_h = 0;
      end else if (i_stall) begin
      end else if (m_h) begin
        m_cur = 0; m_ins = 0; m_v = 0;
      end else if (i_jump) begin
        m_pc = i_pcjump; m_cur = 0;
        m_ins = 0; m_v = 0;
      end else begin
        m_cur = m_pc; m_ins = w; m_v = 1;
        if (w[31:26] == 6'h3f) m_h = 1;
        else m_pc = m_pc + 1;
      end
    end
    if (i_load_we) m_mem[i_load_addr] = i_load_data;
  endtask

  task automatic tick();
    @(posedge i_clock);
    model_step();
    @(negedge i_clock);
  endtask

  task automatic load_word(input logic [7:0] a,
                           input logic [31:0] d);
    i_load_we = 1; i_load_addr = a; i_load_data = d;
    tick();
    i_load_we = 0;
  endtask

  task automatic quiet();
    i_reset = 0; i_stall = 0; i_jump = 0;
    i_branch = 0; i_load_we = 0;
  endtask

  task automatic fill_mem();
    logic [31:0] w;
    for (int a = 0; a < 256; a++) begin
      w = $urandom;
      if (w[31:26] == 6'h3f) w[31:26] = 6'h0;
      load_word(a[7:0], w);
    end
  endtask

  task automatic test_reset();
    quiet();
    i_enable = 0; i_stall = 1;
    i_reset = 1;
    tick();
    i_reset = 0; i_stall = 0;
    checks++;
    if (act_v !== exp_v) begin
      $display("FAIL reset_model got %h want %h",
               act_v, exp_v);
      errors++;
    end
    checks++;
    if ({o_pc, o_currentpc, o_instruccion,
         o_valid, o_halted} !== 98'h0) begin
      $display("FAIL reset_zero pc=%h cur=%h ins=%h v=%b h=%b",
               o_pc, o_currentpc, o_instruccion,
               o_valid, o_halted);
      errors++;
    end
  endtask

  task automatic test_program();
    test_reset();
    load_word(8'd0, 32'h20010005);
    load_word(8'd1, 32'h20020003);
    load_word(8'd2, 32'h00000000);
    load_word(8'd3, 32'hFC000000);
    i_enable = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (o_currentpc !== k || o_valid !== 1'b1) begin
        $display("FAIL prog_pc%0d got %h/%b want %h/1",
                 k, o_currentpc, o_valid, k);
        errors++;
      end
      checks++;
      if (act_v !== exp_v) begin
        $display("FAIL prog_model%0d got %h want %h",
                 k, act_v, exp_v);
        errors++;
      end
    end
    checks++;
    if (o_halted !== 1'b1 || o_instruccion !== 32'hFC000000) begin
      $display("FAIL prog_halt got h=%b ins=%h want 1/fc000000",
               o_halted, o_instruccion);
      errors++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_pc !== 32'd3 || o_valid !== 1'b0 ||
          o_halted !== 1'b1) begin
        $display("FAIL halt_hold got pc=%h v=%b h=%b want 3/0/1",
                 o_pc, o_valid, o_halted);
        errors++;
      end
    end
  endtask

`ifdef FETCH_STEP_EN
  task automatic test_step();
    test_reset();
    i_enable = 1; i_step = 0;
    tick(); tick();
    checks++;
    if (o_pc !== 32'd0) begin
      $display("FAIL step_idle got %h want 0", o_pc);
      errors++;
    end
    for (int k = 0; k < 3; k++) begin
      i_step = 1; tick();
      i_step = 0; tick(); tick();
    end
    checks++;
    if (o_pc !== 32'd3 || act_v !== exp_v) begin
      $display("FAIL step_three got pc=%h want 3", o_pc);
      errors++;
    end
    i_step = 1;
  endtask
`endif

  task automatic test_jump();
    test_reset();
    i_enable = 1;
    tick(); tick(); tick();
    checks++;
    if (o_currentpc !== 32'd2) begin
      $display("FAIL jump_pre got %h want 2", o_currentpc);
      errors++;
    end
    i_jump = 1; i_pcjump = 32'h10;
    tick();
    i_jump = 0;
    checks++;
    if (o_pc !== 32'h10 || o_valid !== 1'b0) begin
      $display("FAIL jump_redir got %h/%b want 10/0",
               o_pc, o_valid);
      errors++;
    end
    tick();
    checks++;
    if (o_currentpc !== 32'h10 || o_valid !== 1'b1 ||
        act_v !== exp_v) begin
      $display("FAIL jump_target got %h/%b want 10/1",
               o_currentpc, o_valid);
      errors++;
    end
  endtask

  task automatic test_stall();
    i_stall = 1; i_jump = 1; i_pcjump = 32'h20;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_pc !== 32'h11 || o_currentpc !== 32'h10 ||
          o_valid !== 1'b1) begin
        $display("FAIL stall_hold%0d got %h/%h/%b want 11/10/1",
                 k, o_pc, o_currentpc, o_valid);
        errors++;
      end
    end
    i_stall = 0;
    tick();
    i_jump = 0;
    checks++;
    if (o_pc !== 32'h20 || o_valid !== 1'b0) begin
      $display("FAIL stall_jump got %h/%b want 20/0",
               o_pc, o_valid);
      errors++;
    end
  endtask

  task automatic test_branch();
    i_branch = 1; i_pcbranch = 32'h8;
    i_stall = 1; i_jump = 1; i_pcjump = 32'h30;
    tick();
    quiet();
    checks++;
    if (o_pc !== 32'h8 || o_valid !== 1'b0) begin
      $display("FAIL branch_prio got %h/%b want 8/0",
               o_pc, o_valid);
      errors++;
    end
    i_branch = 1; i_pcbranch = 32'h3;
    tick();
    i_branch = 0;
    tick();
    tick();
    checks++;
    if (o_halted !== 1'b1 || o_pc !== 32'h3) begin
      $display("FAIL branch_halt got %b/%h want 1/3",
               o_halted, o_pc);
      errors++;
    end
    i_branch = 1; i_pcbranch = 32'h40;
    tick();
    i_branch = 0;
    checks++;
    if (o_halted !== 1'b0 || o_pc !== 32'h40) begin
      $display("FAIL branch_exit got %b/%h want 0/40",
               o_halted, o_pc);
      errors++;
    end
  endtask

  task automatic test_wrap();
    i_enable = 0;
    load_word(8'hFF, 32'h12345678);
    i_enable = 1;
    i_branch = 1; i_pcbranch = 32'hFFFFFFFF;
    tick();
    i_branch = 0;
    tick();
    checks++;
    if (o_pc !== 32'h0 || o_instruccion !== 32'h12345678 ||
        o_currentpc !== 32'hFFFFFFFF) begin
      $display("FAIL wrap got %h/%h/%h want 0/12345678/ffffffff",
               o_pc, o_instruccion, o_currentpc);
      errors++;
    end
  endtask

  task automatic test_same_addr();
    logic [31:0] old;
    old = m_mem[m_pc[7:0]];
    i_load_we = 1; i_load_addr = m_pc[7:0];
    i_load_data = 32'h0BADF00D;
    tick();
    i_load_we = 0;
    checks++;
    if (o_instruccion !== old || act_v !== exp_v) begin
      $display("FAIL same_addr got %h want %h",
               o_instruccion, old);
      errors++;
    end
  endtask

  task automatic test_enable();
    logic [97:0] snap;
    snap = exp_v;
    i_enable = 0;
    for (int k = 0; k < 5; k++) begin
      i_branch = 1'($urandom);
      i_jump = 1'($urandom);
      i_stall = 1'($urandom);
      i_pcbranch = $urandom; i_pcjump = $urandom;
      tick();
      checks++;
      if (act_v !== snap) begin
        $display("FAIL enable_hold%0d got %h want %h",
                 k, act_v, snap);
        errors++;
      end
    end
    quiet();
    i_enable = 1;
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int k = 0; k < 400; k++) begin
      i_reset = ($urandom_range(0, 49) == 0);
      i_enable = ($urandom_range(0, 9) != 0);
`ifdef FETCH_STEP_EN
      i_step = ($urandom_range(0, 3) != 0);
`endif
      i_branch = ($urandom_range(0, 9) == 0);
      i_stall = ($urandom_range(0, 4) == 0);
      i_jump = ($urandom_range(0, 6) == 0);
      i_pcbranch = ($urandom_range(0, 7) == 0) ?
                   $urandom : 32'($urandom_range(0, 63));
      i_pcjump = 32'($urandom_range(0, 63));
      i_load_we = ($urandom_range(0, 4) == 0);
      i_load_addr = 8'($urandom_range(0, 63));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[31:26] = 6'h3f;
      i_load_data = d;
      tick();
      checks++;
      if (act_v !== exp_v) begin
        $display("FAIL random%0d got %h want %h",
                 k, act_v, exp_v);
        errors++;
      end
    end
    quiet();
  endtask

  initial begin
`ifdef FETCH_STEP_EN
    i_step = 1;
`endif
    @(negedge i_clock);
    fill_mem();
    test_reset();
    test_program();
`ifdef FETCH_STEP_EN
    test_step();
`endif
    test_jump();
    test_stall();
    test_branch();
    test_wrap();
    test_same_addr();
    test_enable();
    i_reset = 1; i_enable = 0; i_stall = 1;
    tick();
    quiet();
    checks++;
    if (o_pc !== 32'h0 || o_valid !== 1'b0 ||
        o_halted !== 1'b0) begin
      $display("FAIL mid_reset got %h/%b/%b want 0/0/0",
               o_pc, o_valid, o_halted);
      errors++;
    end
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
